// File: rtl/data_select_pipe.sv
// Two-stage valid/ready pipeline: pass/add/sub/min/max on a signed operand pair plus a running accumulator.
// Optional feature: define DATA_SELECT_SAT_EN to saturate the accumulator instead of wrapping it.
module data_select_pipe #(
  parameter int unsigned DW = 8,
  parameter int unsigned OW = DW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [2:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_c,
  output logic [2:0]    out_op,
  output logic          acc_ovf
);

  localparam int unsigned EXT_W = OW - DW;

  localparam logic [2:0] OP_A   = 3'b000;
  localparam logic [2:0] OP_B   = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_ACC = 3'b100;
  localparam logic [2:0] OP_CLR = 3'b101;
  localparam logic [2:0] OP_MAX = 3'b110;
  localparam logic [2:0] OP_MIN = 3'b111;

`ifdef DATA_SELECT_SAT_EN
  localparam logic [OW-1:0] ACC_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] ACC_MIN = {1'b1, {(OW-1){1'b0}}};
`endif

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } beat_t;

  beat_t         s1_q, s1_d;
  logic          s1_valid_q, s1_valid_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_c_q, out_c_d;
  logic [2:0]    out_op_q, out_op_d;
  logic [OW-1:0] acc_q, acc_d;
  logic          acc_ovf_q, acc_ovf_d;

  logic s2_free;
  logic accept;
  logic advance;

  logic signed [OW-1:0] a_ext;
  logic signed [OW-1:0] b_ext;
  logic        [OW:0]   acc_sum;
  logic                 sum_ovf;
  logic        [OW-1:0] acc_new;
  logic        [OW-1:0] res;

  // Handshake: stage 2 frees up when empty or being drained this edge
  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid_q && s2_free;

  // Stage 1 capture
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_d.op    = in_op;
      s1_d.a     = in_a;
      s1_d.b     = in_b;
      s1_valid_d = 1'b1;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Datapath on the stage-1 beat; the accumulator sum carries one guard bit
  always_comb begin
    a_ext   = {{EXT_W{s1_q.a[DW-1]}}, s1_q.a};
    b_ext   = {{EXT_W{s1_q.b[DW-1]}}, s1_q.b};
    acc_sum = {acc_q[OW-1], acc_q} + {a_ext[OW-1], a_ext};
    sum_ovf = acc_sum[OW] ^ acc_sum[OW-1];
`ifdef DATA_SELECT_SAT_EN
    if (sum_ovf) begin
      acc_new = acc_sum[OW] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_new = acc_sum[OW-1:0];
    end
`else
    acc_new = acc_sum[OW-1:0];
`endif
    res = '0;
    unique case (s1_q.op)
      OP_A:    res = a_ext;
      OP_B:    res = b_ext;
      OP_ADD:  res = a_ext + b_ext;
      OP_SUB:  res = a_ext - b_ext;
      OP_ACC:  res = acc_new;
      OP_CLR:  res = '0;
      OP_MAX:  res = (a_ext > b_ext) ? a_ext : b_ext;
      OP_MIN:  res = (a_ext < b_ext) ? a_ext : b_ext;
      default: res = '0;
    endcase
  end

  // Stage 2: result register and accumulator move only when a beat advances
  always_comb begin
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    out_op_d    = out_op_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    if (s2_free) begin
      out_valid_d = s1_valid_q;
    end
    if (advance) begin
      out_c_d  = res;
      out_op_d = s1_q.op;
      if (s1_q.op == OP_ACC) begin
        acc_d = acc_new;
        if (sum_ovf) begin
          acc_ovf_d = 1'b1;
        end
      end else if (s1_q.op == OP_CLR) begin
        acc_d     = '0;
        acc_ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_op_q    <= '0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_op_q    <= out_op_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_op    = out_op_q;
  assign acc_ovf   = acc_ovf_q;

endmodule
